id_stage: RTL and testbench

//  Decode stage of the 4-stage pipeline (IF -> ID -> EX -> WB). Splits the IF/ID

---
 rtl/id_stage.sv | 193 +++++++++++++++++++
 tb/tb_id_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: splits IF/ID, bypasses same-cycle WB writes, detects load-use hazards.
// Latency 1 cycle into ID/EX; id_stall is combinational and inserts exactly one bubble.
module id_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [DATA_W-1:0]     if_pc,
  output logic                  id_stall,
  output logic [REG_ADDR_W-1:0] rf_rs,
  output logic [REG_ADDR_W-1:0] rf_rt,
  input  logic [DATA_W-1:0]     rf_rd1,
  input  logic [DATA_W-1:0]     rf_rd2,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_wd,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_op_a,
  output logic [DATA_W-1:0]     ex_op_b,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_alu_src,
  output logic [2:0]            ex_alu_op,
  output logic                  ex_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rd_field;
  logic [DATA_W-1:0]     imm_ext;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;

  logic [REG_ADDR_W-1:0] d_dst;
  logic                  d_reg_write;
  logic                  d_mem_read;
  logic                  d_mem_write;
  logic                  d_branch;
  logic                  d_alu_src;
  logic [2:0]            d_alu_op;
  logic                  d_illegal;
  logic                  reads_rt;
  logic                  hazard;
  logic                  capture;

  assign opcode   = if_instr[31:26];
  assign funct    = if_instr[5:0];
  assign rf_rs    = if_instr[25:21];
  assign rf_rt    = if_instr[20:16];
  assign rd_field = if_instr[15:11];
  assign imm_ext  = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};

  always_comb begin
    d_dst       = '0;
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_branch    = 1'b0;
    d_alu_src   = 1'b0;
    d_alu_op    = ALU_ADD;
    d_illegal   = 1'b0;
    reads_rt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reads_rt    = 1'b1;
        d_dst       = rd_field;
        d_reg_write = 1'b1;
        case (funct)
          6'b100000: d_alu_op = ALU_ADD;
          6'b100010: d_alu_op = ALU_SUB;
          6'b100100: d_alu_op = ALU_AND;
          6'b100101: d_alu_op = ALU_OR;
          6'b101010: d_alu_op = ALU_SLT;
          default: begin
            d_illegal   = 1'b1;
            d_dst       = '0;
            d_reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        d_dst       = rf_rt;
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
      end
      OP_LW: begin
        d_dst       = rf_rt;
        d_reg_write = 1'b1;
        d_mem_read  = 1'b1;
        d_alu_src   = 1'b1;
      end
      OP_SW: begin
        reads_rt    = 1'b1;
        d_mem_write = 1'b1;
        d_alu_src   = 1'b1;
      end
      OP_BEQ: begin
        reads_rt = 1'b1;
        d_branch = 1'b1;
        d_alu_op = ALU_SUB;
      end
      default: d_illegal = 1'b1;
    endcase
    // Writes to r0 are discarded, so never advertise them downstream.
    if (d_dst == '0) d_reg_write = 1'b0;
  end

  always_comb begin
    if (rf_rs == '0)                                op_a = '0;
    else if (wb_reg_write && wb_rd == rf_rs)        op_a = wb_wd;
    else                                            op_a = rf_rd1;
    if (rf_rt == '0)                                op_b = '0;
    else if (wb_reg_write && wb_rd == rf_rt)        op_b = wb_wd;
    else                                            op_b = rf_rd2;
  end

  assign hazard   = ex_valid && ex_mem_read && (ex_dst != '0) &&
                    ((ex_dst == rf_rs) || ((ex_dst == rf_rt) && reads_rt));
  assign id_stall = if_valid && hazard && !flush;
  assign capture  = if_valid && !flush && !id_stall;

  // Data fields load unconditionally; only ex_valid and the controls must be bubble-clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
      ex_dst       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_alu_src   <= 1'b0;
      ex_alu_op    <= '0;
      ex_illegal   <= 1'b0;
    end else begin
      ex_pc    <= if_pc;
      ex_op_a  <= op_a;
      ex_op_b  <= op_b;
      ex_imm   <= imm_ext;
      ex_rs    <= rf_rs;
      ex_rt    <= rf_rt;
      ex_valid <= capture;
      if (capture) begin
        ex_dst       <= d_dst;
        ex_reg_write <= d_reg_write;
        ex_mem_read  <= d_mem_read;
        ex_mem_write <= d_mem_write;
        ex_branch    <= d_branch;
        ex_alu_src   <= d_alu_src;
        ex_alu_op    <= d_alu_op;
        ex_illegal   <= d_illegal;
      end else begin
        ex_dst       <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_mem_write <= 1'b0;
        ex_branch    <= 1'b0;
        ex_alu_src   <= 1'b0;
        ex_alu_op    <= '0;
        ex_illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboarded random + directed bench for id_stage against an instruction-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        id_stall;
  logic [4:0]  rf_rs, rf_rt;
  logic [31:0] rf_rd1 = '0, rf_rd2 = '0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_wd = '0;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_imm;
  logic [4:0]  ex_dst, ex_rs, ex_rt;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_illegal;
  logic [2:0]  ex_alu_op;

  id_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_stall(id_stall), .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd1(rf_rd1),
    .rf_rd2(rf_rd2), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_imm(ex_imm), .ex_dst(ex_dst), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  dst, rs, rt;
    bit          rw, mr, mw, br, asrc, ill;
    logic [2:0]  alu;
  } exp_t;

  typedef struct {
    bit         stall;
    logic [4:0] rs, rt;
    exp_t       ex;
  } rec_t;

  rec_t q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [31:0] pc_cnt = 32'h0000_1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t zero_ex();
    exp_t z;
    z.valid = 0; z.pc = '0; z.a = '0; z.b = '0; z.imm = '0;
    z.dst = '0; z.rs = '0; z.rt = '0;
    z.rw = 0; z.mr = 0; z.mw = 0; z.br = 0; z.asrc = 0; z.ill = 0; z.alu = '0;
    return z;
  endfunction

  // Reference decode: instruction semantics straight from the MIPS subset table.
  function automatic exp_t decode(input logic [31:0] ins);
    exp_t e = zero_ex();
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    if (op == 0) begin
      e.dst = ins[15:11]; e.rw = 1;
      if      (fn == 32) e.alu = 0;
      else if (fn == 34) e.alu = 1;
      else if (fn == 36) e.alu = 2;
      else if (fn == 37) e.alu = 3;
      else if (fn == 42) e.alu = 4;
      else begin e.ill = 1; e.dst = 0; e.rw = 0; end
    end else if (op == 8) begin
      e.dst = ins[20:16]; e.rw = 1; e.asrc = 1;
    end else if (op == 35) begin
      e.dst = ins[20:16]; e.rw = 1; e.mr = 1; e.asrc = 1;
    end else if (op == 43) begin
      e.mw = 1; e.asrc = 1;
    end else if (op == 4) begin
      e.br = 1; e.alu = 1;
    end else begin
      e.ill = 1;
    end
    if (e.dst == 0) e.rw = 0;
    return e;
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] r, input bit wbw,
      input logic [4:0] wrd, input logic [31:0] wwd, input logic [31:0] rfv);
    if (r == 0) return 32'd0;
    if (wbw && wrd == r) return wwd;
    return rfv;
  endfunction

  task automatic drive(input bit v, input logic [31:0] ins, input bit fl, input bit wbw,
      input logic [4:0] wrd, input logic [31:0] wwd, input logic [31:0] rd1,
      input logic [31:0] rd2, output bit st);
    rec_t r;
    exp_t n;
    bit   uses_rt, hz;
    logic [4:0] rs, rt;
    @(posedge clk); #1;
    if_valid = v; if_instr = ins; flush = fl; wb_reg_write = wbw; wb_rd = wrd;
    wb_wd = wwd; rf_rd1 = rd1; rf_rd2 = rd2; if_pc = pc_cnt;
    rs = ins[25:21]; rt = ins[20:16];
    uses_rt = (ins[31:26] == 6'd0) || (ins[31:26] == 6'd43) || (ins[31:26] == 6'd4);
    hz = cur.valid && cur.mr && cur.dst != 0 && (cur.dst == rs || (cur.dst == rt && uses_rt));
    st = v && hz && !fl;
    r.stall = st; r.rs = rs; r.rt = rt; r.ex = cur;
    q.push_back(r);
    if (fl || st || !v) n = zero_ex();
    else n = decode(ins);
    n.valid = v && !fl && !st;
    n.pc = pc_cnt; n.imm = {{16{ins[15]}}, ins[15:0]}; n.rs = rs; n.rt = rt;
    n.a = read_reg(rs, wbw, wrd, wwd, rd1);
    n.b = read_reg(rt, wbw, wrd, wwd, rd2);
    cur = n;
    if (!st) pc_cnt += 4;
  endtask

  task automatic issue(input logic [31:0] ins, input bit wbw, input logic [4:0] wrd,
      input logic [31:0] wwd, input logic [31:0] rd1, input logic [31:0] rd2);
    bit st;
    drive(1, ins, 0, wbw, wrd, wwd, rd1, rd2, st);
    for (int i = 0; i < 2 && st; i++) drive(1, ins, 0, wbw, wrd, wwd, rd1, rd2, st);
  endtask

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("id_stall", 32'(id_stall), 32'(r.stall));
        chk("rf_rs", 32'(rf_rs), 32'(r.rs));
        chk("rf_rt", 32'(rf_rt), 32'(r.rt));
        chk("ex_valid", 32'(ex_valid), 32'(r.ex.valid));
        chk("ex_dst", 32'(ex_dst), 32'(r.ex.dst));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(r.ex.rw));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(r.ex.mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(r.ex.mw));
        chk("ex_branch", 32'(ex_branch), 32'(r.ex.br));
        chk("ex_alu_src", 32'(ex_alu_src), 32'(r.ex.asrc));
        chk("ex_alu_op", 32'(ex_alu_op), 32'(r.ex.alu));
        chk("ex_illegal", 32'(ex_illegal), 32'(r.ex.ill));
        if (r.ex.valid) begin
          chk("ex_pc", ex_pc, r.ex.pc);
          chk("ex_op_a", ex_op_a, r.ex.a);
          chk("ex_op_b", ex_op_b, r.ex.b);
          chk("ex_imm", ex_imm, r.ex.imm);
          chk("ex_rs", 32'(ex_rs), 32'(r.ex.rs));
          chk("ex_rt", 32'(ex_rt), 32'(r.ex.rt));
        end
      end
    end
  end

  function automatic logic [31:0] gen_instr();
    logic [5:0]  fns [6];
    logic [5:0]  ops [5];
    logic [4:0]  rs = 5'($urandom_range(0, 7));
    logic [4:0]  rt = 5'($urandom_range(0, 7));
    logic [4:0]  rd = 5'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    int sel = $urandom_range(0, 7);
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'($urandom)};
    ops = '{6'd8, 6'd35, 6'd35, 6'd43, 6'd4};
    if (sel < 2) return {6'd0, rs, rt, rd, 5'd0, fns[$urandom_range(0, 5)]};
    if (sel < 7) return {ops[sel-2], rs, rt, imm};
    return {($urandom_range(0, 1) == 0) ? 6'h3F : 6'($urandom), rs, rt, imm};
  endfunction

  localparam logic [31:0] LW_R4  = {6'd35, 5'd0, 5'd4, 16'd0};
  localparam logic [31:0] ADD_54 = {6'd0, 5'd4, 5'd1, 5'd5, 5'd0, 6'd32};

  initial begin : stim
    bit st;
    bit v;
    logic [31:0] ins;
    cur = zero_ex();
    repeat (2) @(posedge clk);
    #1;
    chk("reset ex_valid", 32'(ex_valid), 32'd0);
    chk("reset id_stall", 32'(id_stall), 32'd0);
    rst_n = 1'b1;

    issue(32'h20010005, 0, 0, 0, 32'h1234, 32'h5678);
    issue({6'd0, 5'd2, 5'd2, 5'd3, 5'd0, 6'd32}, 1, 5'd2, 32'hDEAD, 32'h1111, 32'h1111);
    issue(LW_R4, 0, 0, 0, 0, 0);
    issue(ADD_54, 0, 0, 0, 32'h44, 32'h11);
    issue(LW_R4, 0, 0, 0, 0, 0);
    issue({6'd8, 5'd4, 5'd5, 16'd1}, 0, 0, 0, 32'h44, 0);
    issue(LW_R4, 0, 0, 0, 0, 0);
    issue({6'd35, 5'd4, 5'd6, 16'd0}, 0, 0, 0, 32'h44, 0);
    issue(LW_R4, 0, 0, 0, 0, 0);
    drive(1, ADD_54, 1, 0, 0, 0, 32'h44, 32'h11, st);
    issue(32'hFC000000 | {6'd0, 5'd1, 5'd2, 16'h0007}, 0, 0, 0, 1, 2);
    issue({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd63}, 0, 0, 0, 1, 2);

    // Asynchronous reset while a load-use stall is being signalled.
    issue(LW_R4, 0, 0, 0, 0, 0);
    drive(1, ADD_54, 0, 0, 0, 0, 32'h44, 32'h11, st);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async ex_valid", 32'(ex_valid), 32'd0);
    chk("async ex_mem_read", 32'(ex_mem_read), 32'd0);
    chk("async ex_dst", 32'(ex_dst), 32'd0);
    chk("async ex_reg_write", 32'(ex_reg_write), 32'd0);
    chk("async ex_pc", ex_pc, 32'd0);
    chk("async ex_op_a", ex_op_a, 32'd0);
    chk("async ex_imm", ex_imm, 32'd0);
    chk("async id_stall", 32'(id_stall), 32'd0);
    if_valid = 1'b0;
    flush = 1'b0;
    cur = zero_ex();
    @(posedge clk); #1;
    rst_n = 1'b1;

    st = 0; v = 1; ins = '0;
    for (int i = 0; i < 600; i++) begin
      if (!st) begin
        ins = gen_instr();
        v = ($urandom_range(0, 9) != 0);
      end
      drive(v, ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, st);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: %0d records left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
